// File: rtl/led_pkg.sv
// led_pkg: shared fader state encoding and default parameter values.
package led_pkg;
  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} fader_state_t;
  localparam int PWM_BITS_D = 8;
  localparam int STEP_DIV_D = 2400;
endpackage

// File: rtl/led_pwm.sv
// led_pwm: PWM generator turning a brightness level into a registered LED drive.
//  clock_i, reset_i : clock, synchronous active-high reset
//  level            : requested brightness, latched once per PWM period
//  led_o            : registered PWM output
module led_pwm #(
  parameter int PWM_BITS  = 8,
  parameter int MAX_LEVEL = 255
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [PWM_BITS-1:0] level,
  output logic                led_o
);
  logic [PWM_BITS-1:0] pwm_cnt, level_q;
  // level is only taken at the period boundary so a period never mixes two duties
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pwm_cnt <= '0;
      level_q <= '0;
      led_o   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) level_q <= level;
      led_o   <= (level_q == PWM_BITS'(MAX_LEVEL)) ? 1'b1 : (pwm_cnt < level_q);
    end
  end
endmodule

// File: rtl/led_fader.sv
// led_fader: fades the status LED up and down following the heartbeat pulse.
//  clock_i, reset_i : clock, synchronous active-high reset
//  pulse_i          : heartbeat, high requests full brightness
//  enable_i         : low forces a fade to off
//  led_o            : PWM drive to the LED pad
//  level_o          : current brightness level
//  busy_o           : high while ramping (RISE or FALL)
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_D,
  parameter int MAX_LEVEL = 255,
  parameter int STEP_DIV  = STEP_DIV_D
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                pulse_i,
  input  logic                enable_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                busy_o
);
  localparam int PW = $clog2(STEP_DIV + 1);
  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(MAX_LEVEL);
  logic [PW-1:0] presc;
  logic step, req, busy_n;
  logic [PWM_BITS-1:0] level, level_n;
  fader_state_t state, state_n;
  assign req  = pulse_i & enable_i;
  assign step = presc == PW'(STEP_DIV - 1);
  // level moves in the current direction even when the state flips this cycle
  always_comb begin
    state_n = state;
    level_n = level;
    case (state)
      IDLE: state_n = req ? RISE : IDLE;
      RISE: begin
        level_n = (step && level != MAX) ? level + 1'b1 : level;
        state_n = !req ? FALL : (level_n == MAX) ? HOLD : RISE;
      end
      HOLD: state_n = req ? HOLD : FALL;
      FALL: begin
        level_n = (step && level != '0) ? level - 1'b1 : level;
        state_n = req ? RISE : (level_n == '0) ? IDLE : FALL;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RISE) || (state_n == FALL);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      presc  <= '0;
      state  <= IDLE;
      level  <= '0;
      busy_o <= 1'b0;
    end else begin
      presc  <= step ? '0 : presc + 1'b1;
      state  <= state_n;
      level  <= level_n;
      busy_o <= busy_n;
    end
  end
  assign level_o = level;
  led_pwm #(.PWM_BITS(PWM_BITS), .MAX_LEVEL(MAX_LEVEL)) u_pwm (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .level  (level),
    .led_o  (led_o)
  );
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: scoreboard bench for led_fader with PWM_BITS=4, MAX_LEVEL=15, STEP_DIV=4.
module tb_led_fader;
  logic clk = 1'b0;
  logic reset_i = 1'b1, pulse_i = 1'b0, enable_i = 1'b1;
  logic led_o, busy_o;
  logic [3:0] level_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] lvl;
    logic       busy;
    int         gap;
  } exp_t;
  exp_t exp_q[$];
  bit started = 0, duty_on = 0, seen5 = 0;
  int cyc = 0, last_cyc = 0, hcnt = 0;
  logic [3:0] prev = 4'd0, m_cnt = 4'd0, m_lq = 4'd0, p_lq = 4'd0;
  logic m_led = 1'b0;

  led_fader #(.PWM_BITS(4), .MAX_LEVEL(15), .STEP_DIV(4)) dut (
    .clock_i (clk),
    .reset_i (reset_i),
    .pulse_i (pulse_i),
    .enable_i(enable_i),
    .led_o   (led_o),
    .level_o (level_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int l, input bit b, input int g);
    exp_t e;
    e.lvl  = 4'(l);
    e.busy = b;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_level(input int target, input int budget, input string name);
    int n = 0;
    while (level_o !== 4'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, level_o, target);
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    while (m_cnt !== 4'(c) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_align", m_cnt, c);
  endtask

  // reference PWM built from the published level and a counter restarted by reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_i) begin
      m_cnt <= 4'd0;
      m_lq  <= 4'd0;
      m_led <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'd15) m_lq <= level_o;
      m_led <= (m_lq == 4'd15) || (m_cnt < m_lq);
    end
  end

  // monitor: every level change pops the next expected step
  always @(negedge clk) begin
    if (started) begin
      chk("led_model", led_o, m_led);
      if (m_cnt == 4'd1) begin
        hcnt = 0;
        p_lq = m_lq;
      end
      hcnt += int'(led_o);
      if (m_cnt == 4'd0 && duty_on && p_lq == 4'd5) begin
        chk("duty5", hcnt, 5);
        seen5 = 1;
      end
      if (level_o !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_level: got %0d expected %0d", level_o, prev);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("level", level_o, e.lvl);
          chk("busy_at_step", busy_o, e.busy);
          if (e.gap != 0) chk("step_gap", cyc - last_cyc, e.gap);
        end
        prev = level_o;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    started = 1;
    chk("reset_level", level_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_led", led_o, 0);
    reset_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_level", level_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_led", led_o, 0);
    end
    // rise aligned so a period latches level 5
    wait_cnt(10);
    pulse_i = 1'b1;
    duty_on = 1;
    for (int l = 1; l <= 15; l++) push(l, l != 15, l == 1 ? 0 : 4);
    @(negedge clk);
    chk("rise_busy", busy_o, 1);
    wait_level(15, 200, "reach_15");
    duty_on = 0;
    chk("seen_duty5", seen5, 1);
    repeat (20) @(negedge clk);
    chk("hold_busy", busy_o, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("hold_led", led_o, 1);
    end
    pulse_i = 1'b0;
    for (int l = 14; l >= 0; l--) push(l, l != 0, l == 14 ? 0 : 4);
    wait_level(0, 200, "reach_0");
    repeat (20) @(negedge clk);
    chk("idle_busy2", busy_o, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("off_led", led_o, 0);
    end
    // drop the request on the step cycle at level 7
    pulse_i = 1'b1;
    for (int l = 1; l <= 7; l++) push(l, 1, l == 1 ? 0 : 4);
    begin
      int n = 0;
      while (!(level_o === 4'd7 && m_cnt[1:0] == 2'd3) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("at7_step", level_o, 7);
    end
    pulse_i = 1'b0;
    push(8, 1, 4);
    for (int l = 7; l >= 0; l--) push(l, l != 0, 4);
    @(negedge clk);
    chk("overshoot8", level_o, 8);
    wait_level(0, 200, "fall_done");
    @(negedge clk);
    chk("fall_idle_busy", busy_o, 0);
    // reset in the middle of a rise
    pulse_i = 1'b1;
    for (int l = 1; l <= 9; l++) push(l, 1, l == 1 ? 0 : 4);
    wait_level(9, 200, "reach_9");
    reset_i = 1'b1;
    push(0, 0, 0);
    @(negedge clk);
    chk("rst_level", level_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_led", led_o, 0);
    reset_i = 1'b0;
    enable_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("disabled_level", level_o, 0);
      chk("disabled_busy", busy_o, 0);
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
